// File: rtl/syndrome_dictionary_matcher.sv
// Fault-diagnosis matcher: streams dictionary syndromes against a captured observed
// syndrome and tracks the first closest entry (Hamming distance) plus exact-match count.
module syndrome_dictionary_matcher #(
   parameter int unsigned TESTCOUNT = 117,
   parameter int unsigned ID_W      = 16,
   parameter int unsigned DIST_W    = $clog2(TESTCOUNT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TESTCOUNT-1:0] obs_syndrome,
   input  logic                 ent_valid,
   output logic                 ent_ready,
   input  logic [TESTCOUNT-1:0] ent_syndrome,
   input  logic                 ent_last,
   output logic                 busy,
   output logic                 done,
   output logic [ID_W-1:0]      best_id,
   output logic [DIST_W-1:0]    best_dist,
   output logic [ID_W-1:0]      exact_count,
   output logic [ID_W-1:0]      entry_count,
   output logic                 id_ovf
);

   localparam logic [ID_W-1:0]   ID_MAX   = '1;
   localparam logic [DIST_W-1:0] DIST_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e               state_q;
   logic                 drain_cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic [TESTCOUNT-1:0] obs_q;
   logic                 s1_vld_q;
   logic [TESTCOUNT-1:0] s1_x_q;
   logic [ID_W-1:0]      s1_id_q;
   logic                 s2_vld_q;
   logic [DIST_W-1:0]    s2_dist_q;
   logic [ID_W-1:0]      s2_id_q;
   logic [ID_W-1:0]      best_id_q;
   logic [DIST_W-1:0]    best_dist_q;
   logic [ID_W-1:0]      exact_q;
   logic [ID_W-1:0]      count_q;
   logic                 ovf_q;

   logic accept;
   logic start_ok;

   function automatic logic [DIST_W-1:0] popcount(input logic [TESTCOUNT-1:0] v);
      logic [DIST_W-1:0] c;
      c = '0;
      for (int i = 0; i < TESTCOUNT; i++) begin
         c = c + DIST_W'(v[i]);
      end
      return c;
   endfunction

   assign ent_ready = (state_q == RUN);
   assign accept    = ent_valid & ent_ready;
   assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));

   // Control FSM; DRAIN holds two cycles so the last entry clears S2 and S3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         drain_cnt_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
            end
            RUN: if (accept && ent_last) begin
               state_q     <= DRAIN;
               drain_cnt_q <= 1'b0;
            end
            DRAIN: begin
               drain_cnt_q <= 1'b1;
               if (drain_cnt_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: if (start) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Three-stage compare pipeline plus result/counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obs_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_x_q      <= '0;
         s1_id_q     <= '0;
         s2_vld_q    <= 1'b0;
         s2_dist_q   <= '0;
         s2_id_q     <= '0;
         best_id_q   <= '0;
         best_dist_q <= DIST_MAX;
         exact_q     <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_x_q  <= obs_q ^ ent_syndrome;
            s1_id_q <= count_q;
            if (count_q == ID_MAX) ovf_q   <= 1'b1;
            else                   count_q <= count_q + ID_W'(1);
         end
         s2_vld_q  <= s1_vld_q;
         s2_dist_q <= popcount(s1_x_q);
         s2_id_q   <= s1_id_q;
         if (s2_vld_q) begin
            if (s2_dist_q < best_dist_q) begin
               best_dist_q <= s2_dist_q;
               best_id_q   <= s2_id_q;
            end
            if (s2_dist_q == '0 && exact_q != ID_MAX) exact_q <= exact_q + ID_W'(1);
         end
         if (start_ok) begin
            obs_q       <= obs_syndrome;
            best_id_q   <= '0;
            best_dist_q <= DIST_MAX;
            exact_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign best_id     = best_id_q;
   assign best_dist   = best_dist_q;
   assign exact_count = exact_q;
   assign entry_count = count_q;
   assign id_ovf      = ovf_q;

endmodule
